gsu_mult_unit: RTL and testbench
================================

Name: gsu_mult_unit

Overview:
- Parametrised multi-cycle multiplier for the GSU datapath.
- Sits beside the ALU and is driven by the instruction decoder for the MULT, UMULT, FMULT and LMULT class operations.
- Generalises the single-cycle 16-bit ALU path to WIDTH-bit operands with configurable bits-per-cycle throughput.
- Supports signed/unsigned, integer/fractional result selection and a slow mode that halves the step rate (CFGR MS0 equivalent). Outputs the ALU-style flags.

Parameters:
- WIDTH, 16: operand width. Product is 2*WIDTH bits.
- BPC, 4: multiplier bits retired per step. Legal values are 1, 2, 4 and 8; WIDTH % BPC must be 0, otherwise elaboration error.

Ports:
- clk_21mhz  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned; latched at accept.
- frac  in  1  1 = result word is the upper half (FMULT), 0 = lower half; latched at accept.
- slow  in  1  1 = one step every 2 cycles; latched at accept.
- a  in  WIDTH  multiplicand; latched at accept.
- b  in  WIDTH  multiplier; latched at accept.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse; result and flags are valid from this cycle onward.
- p  out  2*WIDTH  full product, held until the next done.
- z  out  WIDTH  result word: frac ? p[2W-1:W] : p[W-1:0].
- zero  out  1  z == 0.
- sgn  out  1  z[WIDTH-1].
- cy  out  1  frac ? p[WIDTH-1] : 0.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, p=0, z=0, zero=0, sgn=0, cy=0; internal accumulator and operand registers cleared.
- Reset mid-operation aborts immediately to IDLE with the same values; no done pulse is produced.
- States: IDLE, RUN, FINISH.
- IDLE: if start, latch the operands and mode bits, then go to RUN.
  - Operands are latched as magnitudes: |a| and |b| when signed_op=1, raw values otherwise.
  - neg = signed_op & (a[W-1]^b[W-1]).
  - Accumulator is cleared and step counter = 0.
- RUN (busy=1):
  - Each step adds (mag_a * low BPC bits of multiplier) << (step*BPC) into the 2W-bit accumulator, then shifts the multiplier right by BPC.
  - When slow=1, a step occurs only on every second cycle. The first RUN cycle is a wait cycle and the second performs step 0.
  - After step N-1, where N = WIDTH/BPC, go to FINISH.
- FINISH (busy=0, done=1):
  - p <= neg ? -acc : acc, in 2W-bit two's complement.
  - z and the flags update in the same edge.
  - Next state is IDLE, unless start=1 this cycle, in which case operands are latched and the next state is RUN (back-to-back issue).
- Latency from the start-accept edge to the done cycle:
  - N+1 cycles when fast.
  - 2N+1 cycles when slow.
  - WIDTH=16, BPC=4: 5 cycles fast, 9 cycles slow.
- start while busy=1 is ignored. There is no queueing, and a, b and mode changes during RUN have no effect.
- Outputs hold between done pulses, so a new start does not disturb p, z or the flags until its own FINISH.
- Arithmetic widths:
  - Magnitudes are WIDTH bits unsigned; |-2^(W-1)| = 2^(W-1) fits.
  - The accumulator never overflows 2W bits.
  - Signed product -2^(W-1) * -2^(W-1) = 2^(2W-2) is positive and representable.
- A zero operand still takes the full latency; there is no early termination.

Decomposition:
- Shared GSU include file:
  - state encodings: IDLE=2'd0, RUN=2'd1, FINISH=2'd2;
  - result-select constants (RES_LO, RES_HI);
  - the legal-BPC check macro.
- One combinational sub-module, gsu_mult_step:
  - inputs: mag_a (WIDTH), digit (BPC), acc (2W), shift amount;
  - output: next acc.
  - Instantiated once; the parent holds all registers and the FSM.

Test Plan:
- Unsigned, fast, WIDTH=16, BPC=4: a=0xFFFF, b=0xFFFF, signed_op=0, frac=0 -> done 5 cycles after accept, p=0xFFFE0001, z=0x0001, zero=0, sgn=0, cy=0; busy high for exactly 4 cycles.
- Signed fractional: a=0x8000, b=0x8000, signed_op=1, frac=1 -> p=0x40000000, z=0x4000, sgn=0, cy=0. Then a=0x4000, b=0xC000 (-16384) -> p=0xF0000000, z=0xF000, sgn=1, cy=0.
- Slow mode: a=0x0003, b=0x0005, slow=1 -> done 9 cycles after accept, p=0x0000000F; busy high for 8 cycles.
- Back-to-back and ignored start:
  - Pulse start during RUN with a=0x1234 -> ignored; the first result is unaffected.
  - Assert start in the FINISH cycle with a=0x0002, b=0x0002 -> the second done arrives 5 cycles later with p=0x00000004.
  - p holds the first value until then.
- Reset mid-operation: assert reset on the 3rd RUN cycle -> next cycle busy=0, done=0, p=0, zero=0; no done pulse follows. A subsequent start of 0x0000*0x1234 -> p=0, zero=1.
- Parameter sweep: BPC in {1, 2, 8} at WIDTH=16, plus WIDTH=8/BPC=2 -> random signed and unsigned products match the reference model; latency = WIDTH/BPC+1.

Source files
------------

// File: rtl/gsu_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gsu_mult_pkg
//  Description : Shared definitions for the GSU multi-cycle multiplier:
//                FSM state encoding, result-word select constants and the
//                legal step-width check.
//  Revision    : 1.0 - initial release
// ============================================================================
package gsu_mult_pkg;

  // Multiplier control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mult_state_e;

  // Result word select: low half (integer) or high half (fractional)
  localparam logic RES_LO = 1'b0;
  localparam logic RES_HI = 1'b1;

  // A step width is usable when it is a supported radix and tiles the operand
  function automatic bit bpc_is_legal(input int width, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8)) &&
           (width > 0) && ((width % bpc) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gsu_mult_step.sv
`default_nettype none
// ============================================================================
//  Module      : gsu_mult_step
//  Description : One radix-2^BPC multiply step. Adds the magnitude times one
//                multiplier digit, weighted by its bit position, into the
//                double-width accumulator. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module gsu_mult_step #(
  parameter int WIDTH = 16,
  parameter int BPC   = 4,
  parameter int SH_W  = 5
) (
  input  logic [WIDTH-1:0]   i_mag_a,
  input  logic [BPC-1:0]     i_digit,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [SH_W-1:0]    i_shift,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] w_partial;

  // Partial product of one digit, positioned and accumulated; never overflows
  always_comb begin
    w_partial = {{WIDTH{1'b0}}, i_mag_a} * {{(2*WIDTH-BPC){1'b0}}, i_digit};
    o_acc     = i_acc + (w_partial << i_shift);
  end

endmodule
`default_nettype wire

// File: rtl/gsu_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : gsu_mult_unit
//  Description : Parametrised multi-cycle multiplier for the GSU datapath.
//                Signed/unsigned, integer/fractional result select, optional
//                half-rate stepping, ALU-style flags on the result word.
//  Revision    : 1.0 - initial release
// ============================================================================
module gsu_mult_unit
  import gsu_mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BPC   = 4
) (
  input  logic               clk_21mhz,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic               frac,
  input  logic               slow,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic [WIDTH-1:0]   z,
  output logic               zero,
  output logic               sgn,
  output logic               cy
);

  localparam int N      = WIDTH / BPC;
  localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W   = $clog2(2 * WIDTH);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

  generate
    if (!bpc_is_legal(WIDTH, BPC)) begin : g_bpc_illegal
      $error("gsu_mult_unit: BPC must be 1, 2, 4 or 8 and divide WIDTH");
    end
  endgenerate

  mult_state_e        r_state;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_acc;
  logic [STEP_W-1:0]  r_step;
  logic               r_neg;
  logic               r_frac;
  logic               r_slow;
  logic               r_phase;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_z;
  logic               r_zero;
  logic               r_sgn;
  logic               r_cy;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_neg;
  logic               w_accept;
  logic               w_step_en;
  logic               w_last;
  logic [SH_W-1:0]    w_shift;
  logic [2*WIDTH-1:0] w_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_z;

  gsu_mult_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC),
    .SH_W  (SH_W)
  ) u_step (
    .i_mag_a (r_mag_a),
    .i_digit (r_mplr[BPC-1:0]),
    .i_acc   (r_acc),
    .i_shift (w_shift),
    .o_acc   (w_next)
  );

  // Operand conditioning, step qualification and final sign/word selection
  always_comb begin
    w_mag_a   = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    w_mag_b   = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    w_neg     = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    // FINISH accepts too, which gives back-to-back issue
    w_accept  = start && (r_state != RUN);
    // In slow mode the first RUN cycle is a wait cycle, steps on odd phases
    w_step_en = (r_state == RUN) && (!r_slow || r_phase);
    w_last    = (r_step == LAST_STEP);
    w_shift   = SH_W'(r_step) * SH_W'(BPC);
    // The final step's sum is the full magnitude; result registers load it
    // on the same edge so p and flags are valid while done is high
    w_prod    = r_neg ? (~w_next + 1'b1) : w_next;
    w_z       = (r_frac == RES_HI) ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
  end

  // Control FSM, operand/accumulator registers and held result/flag registers
  always_ff @(posedge clk_21mhz) begin
    if (reset) begin
      r_state <= IDLE;
      r_mag_a <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_step  <= '0;
      r_neg   <= 1'b0;
      r_frac  <= RES_LO;
      r_slow  <= 1'b0;
      r_phase <= 1'b0;
      r_p     <= '0;
      r_z     <= '0;
      r_zero  <= 1'b0;
      r_sgn   <= 1'b0;
      r_cy    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        RUN: begin
          r_phase <= ~r_phase;
          if (w_step_en) begin
            r_acc  <= w_next;
            r_mplr <= r_mplr >> BPC;
            r_step <= r_step + 1'b1;
            if (w_last) begin
              r_p     <= w_prod;
              r_z     <= w_z;
              r_zero  <= (w_z == '0);
              r_sgn   <= w_z[WIDTH-1];
              r_cy    <= (r_frac == RES_HI) ? w_prod[WIDTH-1] : 1'b0;
              r_state <= FINISH;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // Accept overrides the IDLE/FINISH successor chosen above
      if (w_accept) begin
        r_mag_a <= w_mag_a;
        r_mplr  <= w_mag_b;
        r_neg   <= w_neg;
        r_frac  <= frac;
        r_slow  <= slow;
        r_acc   <= '0;
        r_step  <= '0;
        r_phase <= 1'b0;
        r_state <= RUN;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == FINISH);
  assign p    = r_p;
  assign z    = r_z;
  assign zero = r_zero;
  assign sgn  = r_sgn;
  assign cy   = r_cy;

endmodule
`default_nettype wire

// File: tb/tb_gsu_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gsu_mult_unit
//  Description : Scoreboard bench for gsu_mult_unit. Stimulus pushes the
//                reference result (signed arithmetic on 64-bit integers) and
//                its due cycle; per-instance monitors pop on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gsu_mult_unit;

  typedef struct {
    longint unsigned p;
    longint unsigned z;
    bit              zero;
    bit              sgn;
    bit              cy;
    int              due;
    int              busy_n;
  } exp_t;

  logic clk;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: interpret operands as integers, multiply, take 2W-bit pattern
  function automatic exp_t model(input int w, input int bpc, input longint unsigned av,
                                 input longint unsigned bv, input bit s, input bit f,
                                 input bit sl, input int now);
    exp_t            e;
    longint          sa;
    longint          sb;
    longint          prod;
    longint unsigned mask_w;
    longint unsigned mask_p;
    mask_w = (64'd1 << w) - 64'd1;
    mask_p = (64'd1 << (2 * w)) - 64'd1;
    sa = longint'(av & mask_w);
    sb = longint'(bv & mask_w);
    if (s && av[w-1]) sa = sa - longint'(64'd1 << w);
    if (s && bv[w-1]) sb = sb - longint'(64'd1 << w);
    prod     = sa * sb;
    e.p      = longint'(prod) & mask_p;
    e.z      = f ? (e.p >> w) : (e.p & mask_w);
    e.zero   = (e.z == 0);
    e.sgn    = e.z[w-1];
    e.cy     = f ? e.p[w-1] : 1'b0;
    e.busy_n = sl ? 2 * (w / bpc) : (w / bpc);
    e.due    = now + e.busy_n + 1;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input longint unsigned pv,
                         input longint unsigned zv, input bit zr, input bit sg,
                         input bit cv, input int bcnt);
    check({tag, ".p"}, pv, e.p);
    check({tag, ".z"}, zv, e.z);
    check({tag, ".zero"}, zr, e.zero);
    check({tag, ".sgn"}, sg, e.sgn);
    check({tag, ".cy"}, cv, e.cy);
    check({tag, ".latency_cycle"}, cyc, e.due);
    check({tag, ".busy_cycles"}, bcnt, e.busy_n);
  endtask

  // ---------------- main instance: WIDTH=16, BPC=4 ----------------
  logic        rst0, start0, sop0, frac0, slow0;
  logic [15:0] a0, b0, z0;
  logic        busy0, done0, zero0, sgn0, cy0;
  logic [31:0] p0;
  exp_t        q0[$];
  exp_t        e0;
  int          bcnt0 = 0;

  gsu_mult_unit #(.WIDTH(16), .BPC(4)) u_dut (
    .clk_21mhz (clk),    .reset (rst0),  .start (start0),
    .signed_op (sop0),   .frac  (frac0), .slow  (slow0),
    .a         (a0),     .b     (b0),
    .busy      (busy0),  .done  (done0), .p     (p0),
    .z         (z0),     .zero  (zero0), .sgn   (sgn0), .cy (cy0)
  );

  always @(negedge clk) begin
    if (rst0) begin
      q0.delete();
      bcnt0 = 0;
    end else begin
      if (busy0) bcnt0++;
      if (done0) begin
        check("main.done_was_expected", (q0.size() > 0), 1);
        if (q0.size() > 0) begin
          e0 = q0.pop_front();
          compare("main", e0, p0, z0, zero0, sgn0, cy0, bcnt0);
        end
        bcnt0 = 0;
      end
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input bit s, input bit f, input bit sl);
    a0 = ia; b0 = ib; sop0 = s; frac0 = f; slow0 = sl; start0 = 1'b1;
    q0.push_back(model(16, 4, ia, ib, s, f, sl, cyc));
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("main.done_within_budget", done0, 1);
  endtask

  // ---------------- parameter sweep instances ----------------
  logic sw_rst;

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int W = (g == 3) ? 8 : 16;
    localparam int B = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 2;
    logic           st, so, fr, sl, bs, dn, zr, sg, cv;
    logic [W-1:0]   av, bv, zv;
    logic [2*W-1:0] pv;
    exp_t           q[$];
    exp_t           e;
    int             bcnt = 0;
    bit             fin = 1'b0;

    gsu_mult_unit #(.WIDTH(W), .BPC(B)) u_dut (
      .clk_21mhz (clk), .reset (sw_rst), .start (st),
      .signed_op (so),  .frac  (fr),     .slow  (sl),
      .a         (av),  .b     (bv),
      .busy      (bs),  .done  (dn),     .p     (pv),
      .z         (zv),  .zero  (zr),     .sgn   (sg), .cy (cv)
    );

    always @(negedge clk) begin
      if (sw_rst) begin
        q.delete();
        bcnt = 0;
      end else begin
        if (bs) bcnt++;
        if (dn) begin
          check($sformatf("sweep%0d.done_was_expected", g), (q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            compare($sformatf("sweep%0d", g), e, pv, zv, zr, sg, cv, bcnt);
          end
          bcnt = 0;
        end
      end
    end

    initial begin
      st = 1'b0; so = 1'b0; fr = 1'b0; sl = 1'b0; av = '0; bv = '0;
      @(negedge clk);
      while (sw_rst) @(negedge clk);
      for (int i = 0; i < 24; i++) begin
        int k;
        av = (i == 0) ? {W{1'b1}} : (i == 1) ? {1'b1, {(W-1){1'b0}}} : W'($urandom);
        bv = (i == 0) ? {W{1'b1}} : (i == 1) ? {1'b1, {(W-1){1'b0}}} : W'($urandom);
        so = (i < 2) ? i[0] : 1'($urandom_range(0, 1));
        fr = 1'($urandom_range(0, 1));
        sl = (i < 4) ? 1'b0 : 1'($urandom_range(0, 1));
        q.push_back(model(W, B, av, bv, so, fr, sl, cyc));
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        k = 0;
        while (!dn && k < 100) begin
          @(negedge clk);
          k++;
        end
        check($sformatf("sweep%0d.done_within_budget", g), dn, 1);
        @(negedge clk);
      end
      fin = 1'b1;
    end
  end

  // ---------------- main directed + random sequence ----------------
  initial begin
    int ndone;
    int k;
    rst0 = 1'b1; sw_rst = 1'b1;
    start0 = 1'b0; sop0 = 1'b0; frac0 = 1'b0; slow0 = 1'b0; a0 = '0; b0 = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", busy0, 0);
    check("reset.done", done0, 0);
    check("reset.p", p0, 0);
    check("reset.z", z0, 0);
    check("reset.zero", zero0, 0);
    check("reset.sgn", sgn0, 0);
    check("reset.cy", cy0, 0);
    rst0 = 1'b0; sw_rst = 1'b0;
    @(negedge clk);

    // Unsigned full-scale, then signed fractional corners, then slow mode
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0); wait_done(20); @(negedge clk);
    issue(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0); wait_done(20); @(negedge clk);
    issue(16'h4000, 16'hC000, 1'b1, 1'b1, 1'b0); wait_done(20); @(negedge clk);
    issue(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b1); wait_done(30); @(negedge clk);

    // Start during RUN is ignored; start in the done cycle issues back-to-back
    issue(16'h0005, 16'h0007, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a0 = 16'h1234; b0 = 16'h1111; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; a0 = '0; b0 = '0;
    wait_done(20);
    issue(16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("b2b.p_held", p0, 32'd35);
      @(negedge clk);
    end
    wait_done(20); @(negedge clk);

    // Reset on the third RUN cycle aborts without a done pulse
    issue(16'h0009, 16'h0009, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    check("abort.busy", busy0, 0);
    check("abort.done", done0, 0);
    check("abort.p", p0, 0);
    check("abort.zero", zero0, 0);
    @(negedge clk);
    rst0 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    check("abort.no_done_after", ndone, 0);
    issue(16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0); wait_done(20); @(negedge clk);

    // Random traffic, sometimes issued back-to-back from the done cycle
    for (int i = 0; i < 30; i++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done(30);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    wait_done(30);
    @(negedge clk);
    check("main.queue_drained", q0.size(), 0);

    k = 0;
    while (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("sweep.all_finished", (g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
